// File: rtl/action_sequencer_pkg.sv
// Shared encodings for the chef action sequencer: states, op codes, func codes
// and the feedback bit assignments.
package action_sequencer_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MOVE   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  typedef enum logic [1:0] {
    OP_ACTION = 2'b00,
    OP_WAIT   = 2'b01,
    OP_JUMP   = 2'b10,
    OP_END    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    FUNC_GET      = 2'd0,
    FUNC_PUT      = 2'd1,
    FUNC_INTERACT = 2'd2,
    FUNC_THROW    = 2'd3
  } func_e;

  localparam int unsigned FB_MOVE_READY = 2;
  localparam logic        ENABLED       = 1'b1;

  function automatic op_e instr_op(input logic [15:0] instr);
    return op_e'(instr[15:14]);
  endfunction

endpackage

// File: rtl/action_sequencer_cycle_counter.sv
// Loadable down-counter with zero flag; shared by the WAIT and HOLD phases.
module cycle_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/action_sequencer.sv
// Script-driven controller: fetches 16-bit instructions from a synchronous ROM
// and sequences the action block's en/i_num/func one action at a time.
module action_sequencer
  import action_sequencer_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned MOVE_TMO = 1000,
  parameter int unsigned ACT_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  output logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  input  logic [7:0]      feedback_sig,
  output logic            act_en,
  output logic [7:0]      act_i_num,
  output logic [1:0]      act_func,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int unsigned TMO_W = (MOVE_TMO > 2) ? $clog2(MOVE_TMO) : 1;
  localparam int unsigned CNT_W = ($clog2(ACT_HOLD) > 8) ? $clog2(ACT_HOLD) : 8;

  logic [2:0]       state;
  logic [PC_W-1:0]  pc;
  logic [TMO_W-1:0] tmo;

  op_e              op;
  logic             move_ready;
  logic             jump_taken;
  logic             cnt_clear;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             unused_bits;

  assign prog_addr   = pc;
  assign unused_bits = ^prog_data;

  // The counter is steered from the same state/stop view as the main FSM so
  // WAIT and HOLD share one instance without extra state.
  always_comb begin
    op         = instr_op(prog_data);
    move_ready = feedback_sig[FB_MOVE_READY];
    jump_taken = (feedback_sig[prog_data[13:11]] == prog_data[10]);
    cnt_clear  = stop;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = CNT_W'(ACT_HOLD - 1);
    if (!stop) begin
      case (state)
        S_DECODE: begin
          if (op == OP_WAIT) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(prog_data[7:0]);
          end
        end
        S_MOVE:         cnt_load = move_ready;
        S_HOLD, S_WAIT: cnt_dec  = 1'b1;
        default:        ;
      endcase
    end
  end

  cycle_counter #(.W(CNT_W)) u_cycle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      tmo       <= '0;
      act_en    <= 1'b0;
      act_i_num <= '0;
      act_func  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else if (stop) begin
      state  <= S_IDLE;
      tmo    <= '0;
      act_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_ACTION: begin
              state     <= S_MOVE;
              act_en    <= ENABLED;
              act_func  <= prog_data[13:12];
              act_i_num <= prog_data[7:0];
              tmo       <= '0;
            end
            OP_WAIT: state <= S_WAIT;
            OP_JUMP: begin
              state <= S_FETCH;
              pc    <= jump_taken ? prog_data[PC_W-1:0] : pc + PC_W'(1);
            end
            OP_END: begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          endcase
        end
        S_MOVE: begin
          if (move_ready) begin
            state <= S_HOLD;
          end else if (tmo == TMO_W'(MOVE_TMO - 1)) begin
            state  <= S_ERR;
            act_en <= 1'b0;
            busy   <= 1'b0;
            error  <= 1'b1;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            state  <= S_FETCH;
            act_en <= 1'b0;
            pc     <= pc + PC_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt_zero) begin
            state <= S_FETCH;
            pc    <= pc + PC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_action_sequencer.sv
// Bench for action_sequencer: ROM model, table-driven action vectors with a
// scoreboard of expected act pulses, plus sequences for timing corner cases.
module tb_action_sequencer;
  import action_sequencer_pkg::*;

  localparam int unsigned MOVE_TMO = 1000;
  localparam int unsigned ACT_HOLD = 4;
  localparam logic [15:0] I_END    = 16'hC000;
  localparam int          NEVER    = 1000000;

  logic        clk = 1'b0;
  logic        rst_n, start, stop;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic [7:0]  feedback_sig;
  logic        act_en, busy, done, error;
  logic [7:0]  act_i_num;
  logic [1:0]  act_func;

  logic [15:0] rom [256];
  logic        mr_drv = 1'b0;
  logic        fb2_force = 1'b0;
  logic        fb0_force = 1'b0;
  int          ready_after = 1;
  bit          pulse_mode = 1'b0;
  bit          mon_ignore = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] i_num;
    logic [1:0] func;
    int         len;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] func;
    logic [7:0] i_num;
    int         ready_after;
    bit         pulse;
    int         exp_len;
  } act_vec_t;

  typedef struct {
    logic [2:0] k;
    logic       pol;
    logic       fb2;
    logic       fb0;
    logic [7:0] tgt;
    logic [7:0] exp_addr;
  } jmp_vec_t;

  action_sequencer #(.PC_W(8), .MOVE_TMO(MOVE_TMO), .ACT_HOLD(ACT_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .feedback_sig (feedback_sig),
    .act_en       (act_en),
    .act_i_num    (act_i_num),
    .act_func     (act_func),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= rom[prog_addr];

  assign feedback_sig = {5'b0, mr_drv | fb2_force, 1'b0, fb0_force};

  function automatic logic [15:0] i_action(logic [1:0] f, logic [7:0] n);
    return {2'b00, f, 4'b0000, n};
  endfunction
  function automatic logic [15:0] i_wait(logic [7:0] n);
    return {2'b01, 6'b0, n};
  endfunction
  function automatic logic [15:0] i_jump(logic [2:0] k, logic pol, logic [7:0] t);
    return {2'b10, k, pol, 2'b00, t};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Act-pulse monitor: drives move_ready relative to the pulse and pops the
  // scoreboard when the pulse ends.
  logic       prev_en = 1'b0;
  int         cur_len = 0;
  logic [7:0] cur_i;
  logic [1:0] cur_f;
  logic       stable;
  always @(negedge clk) begin
    if (act_en === 1'b1) begin
      if (!prev_en) begin
        cur_len = 0;
        cur_i   = act_i_num;
        cur_f   = act_func;
        stable  = 1'b1;
      end else if (act_i_num !== cur_i || act_func !== cur_f) begin
        stable = 1'b0;
      end
      cur_len++;
      mr_drv = pulse_mode ? (cur_len == ready_after) : (cur_len >= ready_after);
    end else begin
      mr_drv = 1'b0;
      if (prev_en) begin
        if (mon_ignore) begin
          mon_ignore = 1'b0;
        end else if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL act_unexpected: got pulse i_num=%0h expected none", cur_i);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("act_len", cur_len, e.len);
          chk("act_i_num", {24'b0, cur_i}, {24'b0, e.i_num});
          chk("act_func", {30'b0, cur_f}, {30'b0, e.func});
          chk("act_stable", {31'b0, stable}, 32'd1);
        end
      end
    end
    prev_en = (act_en === 1'b1);
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = I_END;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_level(logic val, int budget, string name);
    for (int i = 0; i < budget; i++) begin
      if (act_en === val) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL %s: got timeout expected act_en=%0b", name, val);
  endtask

  task automatic wait_done(int budget, string name);
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1 || error === 1'b1) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL %s: got timeout expected done/error", name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    act_vec_t vecs[5];
    jmp_vec_t jmps[4];
    int       waits[3];
    int       gap;

    vecs[0] = '{FUNC_PUT,      8'h05, 10, 1'b0, 14};
    vecs[1] = '{FUNC_GET,      8'hA3,  1, 1'b0,  5};
    vecs[2] = '{FUNC_INTERACT, 8'h00,  3, 1'b1,  7};
    vecs[3] = '{FUNC_THROW,    8'hFF,  2, 1'b0,  6};
    vecs[4] = '{FUNC_PUT,      8'h42,  1, 1'b1,  5};

    jmps[0] = '{3'd2, 1'b1, 1'b1, 1'b0, 8'h10, 8'h10};
    jmps[1] = '{3'd2, 1'b1, 1'b0, 1'b0, 8'h10, 8'h01};
    jmps[2] = '{3'd0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h20};
    jmps[3] = '{3'd0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h01};

    waits[0] = 0;
    waits[1] = 7;
    waits[2] = 3;

    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    clear_rom();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_prog_addr", {24'b0, prog_addr}, 32'h0);
    chk("rst_act_en", {31'b0, act_en}, 32'h0);
    chk("rst_act_i_num", {24'b0, act_i_num}, 32'h0);
    chk("rst_act_func", {30'b0, act_func}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_error", {31'b0, error}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ACTION + END programs
    foreach (vecs[v]) begin
      clear_rom();
      rom[0]      = i_action(vecs[v].func, vecs[v].i_num);
      ready_after = vecs[v].ready_after;
      pulse_mode  = vecs[v].pulse;
      sb.push_back('{vecs[v].i_num, vecs[v].func, vecs[v].exp_len});
      pulse_start();
      chk("lat_busy", {31'b0, busy}, 32'h1);
      chk("lat_fetch_en", {31'b0, act_en}, 32'h0);
      @(negedge clk);
      chk("lat_decode_en", {31'b0, act_en}, 32'h0);
      @(negedge clk);
      chk("lat_act_en", {31'b0, act_en}, 32'h1);
      wait_done(200, "act_done_wait");
      chk("act_done", {31'b0, done}, 32'h1);
      chk("act_busy", {31'b0, busy}, 32'h0);
      chk("act_error", {31'b0, error}, 32'h0);
      chk("sb_drained", sb.size(), 32'h0);
    end
    pulse_mode  = 1'b0;
    ready_after = 1;

    // WAIT n: act_en low for FETCH+DECODE+(n+1)+FETCH+DECODE cycles
    foreach (waits[w]) begin
      clear_rom();
      rom[0] = i_action(FUNC_GET, 8'h01);
      rom[1] = i_wait(8'(waits[w]));
      rom[2] = i_action(FUNC_GET, 8'h02);
      sb.push_back('{8'h01, FUNC_GET, 5});
      sb.push_back('{8'h02, FUNC_GET, 5});
      pulse_start();
      wait_level(1'b1, 20, "wait_rise");
      wait_level(1'b0, 20, "wait_fall");
      gap = 0;
      for (int i = 0; i < 300 && act_en !== 1'b1; i++) begin
        gap++;
        @(negedge clk);
      end
      chk("wait_gap", gap, waits[w] + 5);
      wait_done(100, "wait_done_wait");
      chk("wait_done", {31'b0, done}, 32'h1);
    end

    // Conditional JUMP
    foreach (jmps[j]) begin
      clear_rom();
      rom[0]    = i_jump(jmps[j].k, jmps[j].pol, jmps[j].tgt);
      fb2_force = jmps[j].fb2;
      fb0_force = jmps[j].fb0;
      pulse_start();
      repeat (2) @(negedge clk);
      chk("jump_fetch_addr", {24'b0, prog_addr}, {24'b0, jmps[j].exp_addr});
      wait_done(20, "jump_done_wait");
      chk("jump_done", {31'b0, done}, 32'h1);
    end
    fb2_force = 1'b0;
    fb0_force = 1'b0;

    // Move timeout, then start clears the error
    clear_rom();
    rom[0]      = i_action(FUNC_THROW, 8'h07);
    ready_after = NEVER;
    sb.push_back('{8'h07, FUNC_THROW, MOVE_TMO});
    pulse_start();
    wait_done(MOVE_TMO + 50, "tmo_wait");
    chk("tmo_error", {31'b0, error}, 32'h1);
    chk("tmo_act_en", {31'b0, act_en}, 32'h0);
    chk("tmo_busy", {31'b0, busy}, 32'h0);
    chk("tmo_done", {31'b0, done}, 32'h0);
    repeat (3) @(negedge clk);
    chk("tmo_sticky", {31'b0, error}, 32'h1);
    ready_after = 1;
    sb.push_back('{8'h07, FUNC_THROW, 5});
    pulse_start();
    chk("tmo_cleared", {31'b0, error}, 32'h0);
    wait_done(50, "tmo_restart_wait");
    chk("tmo_restart_done", {31'b0, done}, 32'h1);

    // stop together with start while in S_MOVE
    clear_rom();
    rom[0]      = i_action(FUNC_PUT, 8'h09);
    ready_after = NEVER;
    pulse_start();
    wait_level(1'b1, 10, "stop_rise");
    repeat (3) @(negedge clk);
    mon_ignore = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("stop_act_en", {31'b0, act_en}, 32'h0);
    chk("stop_busy", {31'b0, busy}, 32'h0);
    chk("stop_done", {31'b0, done}, 32'h0);
    repeat (3) @(negedge clk);
    chk("stop_idle", {31'b0, busy}, 32'h0);
    ready_after = 1;

    // Async reset during the HOLD of the second action
    clear_rom();
    rom[0] = i_action(FUNC_GET, 8'h01);
    rom[1] = i_action(FUNC_GET, 8'h33);
    sb.push_back('{8'h01, FUNC_GET, 5});
    pulse_start();
    wait_level(1'b1, 10, "rst_rise1");
    wait_level(1'b0, 20, "rst_fall1");
    wait_level(1'b1, 10, "rst_rise2");
    @(negedge clk);
    chk("rst_hold_addr", {24'b0, prog_addr}, 32'h1);
    #2;
    mon_ignore = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_act_en", {31'b0, act_en}, 32'h0);
    chk("arst_prog_addr", {24'b0, prog_addr}, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_i_num", {24'b0, act_i_num}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{8'h01, FUNC_GET, 5});
    sb.push_back('{8'h33, FUNC_GET, 5});
    pulse_start();
    wait_done(100, "arst_restart_wait");
    chk("arst_restart_done", {31'b0, done}, 32'h1);
    chk("arst_sb_drained", sb.size(), 32'h0);

    // pc wraps from 0xFF to 0
    clear_rom();
    rom[0]    = i_jump(3'd0, 1'b1, 8'hFF);
    rom[255]  = i_action(FUNC_PUT, 8'h77);
    fb0_force = 1'b1;
    sb.push_back('{8'h77, FUNC_PUT, 5});
    pulse_start();
    wait_level(1'b1, 20, "wrap_rise");
    wait_level(1'b0, 20, "wrap_fall");
    chk("wrap_addr", {24'b0, prog_addr}, 32'h0);
    fb0_force = 1'b0;
    wait_done(20, "wrap_done_wait");
    chk("wrap_done", {31'b0, done}, 32'h1);
    chk("wrap_final_addr", {24'b0, prog_addr}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
